// File: rtl/teclado_decimal_antirrebote_pkg.sv
// Shared types and helpers for the decimal keypad front-end and the 1-of-10 code converter bench.
package teclado_pkg;
  localparam int NUM_TECLAS = 10;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HOLD,
    WAIT_RELEASE
  } estado_t;

  // A word is one-hot when it is non-zero and clearing its lowest set bit leaves nothing.
  function automatic logic es_onehot(input logic [NUM_TECLAS-1:0] v);
    return (v != '0) && ((v & (v - NUM_TECLAS'(1))) == '0);
  endfunction

  function automatic logic mas_de_una(input logic [NUM_TECLAS-1:0] v);
    return (v & (v - NUM_TECLAS'(1))) != '0;
  endfunction
endpackage

// File: rtl/teclado_decimal_antirrebote_if.sv
// Output bus of the keypad front-end: registered one-hot digit, valid/ack handshake, error pulse.
interface teclado_decimal_antirrebote_if;
  import teclado_pkg::*;

  // valid rises with a one-hot D and both hold steady until ack is sampled high on a rising
  // edge while valid=1; that edge drops valid and clears D. ack while valid=0 is ignored.
  logic [NUM_TECLAS-1:0] D;
  logic                  valid;
  logic                  ack;
  logic                  multi_err;

  modport master (output D, output valid, output multi_err, input ack);
  modport slave  (input D, input valid, input multi_err, output ack);
endinterface

// File: rtl/teclado_decimal_antirrebote_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared to zero on reset.
module sincronizador_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/teclado_decimal_antirrebote.sv
// Keypad front-end: synchronise, debounce, reject multi-key presses, one valid/ack per press.
// Optional auto-repeat of a held key is compiled in with `define AUTOREPEAT_EN.
module teclado_decimal_antirrebote
  import teclado_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
`ifdef AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 1024
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_TECLAS-1:0]        teclas,
  teclado_decimal_antirrebote_if.master bus,
  output estado_t                      dbg_state
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] r_rep;
`endif

  logic [NUM_TECLAS-1:0] w_teclas_s;
  estado_t               r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_TECLAS-1:0] r_cand;
  logic [NUM_TECLAS-1:0] r_d;
  logic                  r_valid;
  logic                  r_multi;

  sincronizador_2ff #(.W(NUM_TECLAS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (teclas),
    .o_q   (w_teclas_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_d     <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
`ifdef AUTOREPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_multi <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mas_de_una(w_teclas_s)) begin
            r_multi <= 1'b1;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_state <= WAIT_RELEASE;
          end else if (w_teclas_s != '0) begin
            r_cand  <= w_teclas_s;
            r_cnt   <= '0;
            r_state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (w_teclas_s == r_cand) begin
            if (r_cnt == CNT_LAST) begin
              r_d     <= r_cand;
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_state <= HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        HOLD: begin
          // Key activity is deliberately ignored here so an accepted press waits for its ack.
          if (bus.ack) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_cnt   <= '0;
`ifdef AUTOREPEAT_EN
            r_rep   <= '0;
`endif
            r_state <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (w_teclas_s == '0) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_cnt <= '0;
          end
`ifdef AUTOREPEAT_EN
          // r_cand is zero after a multi-key press, so a rejected chord never repeats.
          if ((r_cand != '0) && (w_teclas_s == r_cand)) begin
            if (r_rep == REP_LAST) begin
              r_rep   <= '0;
              r_d     <= r_cand;
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_state <= HOLD;
            end else begin
              r_rep <= r_rep + REP_W'(1);
            end
          end else begin
            r_rep <= '0;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.D         = r_d;
  assign bus.valid     = r_valid;
  assign bus.multi_err = r_multi;
  assign dbg_state     = r_state;
endmodule

// File: tb/tb_teclado_decimal_antirrebote.sv
// Bench for the keypad front-end with DEBOUNCE_CYCLES=4 (REPEAT_CYCLES=8 when AUTOREPEAT_EN is set).
module tb_teclado_decimal_antirrebote;
  import teclado_pkg::*;

  localparam int DC  = 4;
  localparam int LAT = DC + 3;
`ifdef AUTOREPEAT_EN
  localparam int RC   = 8;
  localparam int LMAX = DC + 3;
`else
  localparam int LMAX = 20;
`endif
  localparam int SETTLE = 40;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_TECLAS-1:0] teclas = '0;
  estado_t               dbg_state;
  teclado_decimal_antirrebote_if bus();

  always #5 clk = ~clk;

  teclado_decimal_antirrebote #(
    .DEBOUNCE_CYCLES(DC)
`ifdef AUTOREPEAT_EN
    , .REPEAT_CYCLES(RC)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .teclas    (teclas),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- ack generation ----------------
  logic auto_ack = 1'b1;
  logic man_ack = 1'b0;
  logic auto_ack_q = 1'b0;
  int   ack_dly = 0;
  int   ack_cnt = 0;

  assign bus.ack = auto_ack ? auto_ack_q : man_ack;

  always @(negedge clk) begin
    if (!bus.valid) begin
      auto_ack_q = 1'b0;
      ack_cnt    = 0;
    end else if (ack_cnt >= ack_dly) begin
      auto_ack_q = 1'b1;
    end else begin
      ack_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [NUM_TECLAS-1:0] exp_q[$];
  int n_rise = 0;
  int n_multi = 0;
  int cyc = 0;
  int rise_cyc_q[$];
  logic prev_valid = 1'b0;
  logic prev_multi = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    check("invariant_D_vs_valid",
          {31'd0, (bus.valid ? es_onehot(bus.D) : (bus.D == '0))}, 32'd1);
    if (bus.valid && !prev_valid) begin
      n_rise++;
      rise_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_valid_D", {22'd0, bus.D}, 32'd0);
      else check("valid_D", {22'd0, bus.D}, {22'd0, exp_q.pop_front()});
    end
    if (bus.multi_err) begin
      n_multi++;
      check("multi_err_width", {31'd0, prev_multi}, 32'd0);
    end
    prev_valid = bus.valid;
    prev_multi = bus.multi_err;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts rising edges from the current negedge until valid is seen; 60 means it never came.
  task automatic wait_valid(output int k);
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus.valid) break;
    end
  endtask

  task automatic session(input logic [NUM_TECLAS-1:0] key, input int len);
    teclas = key;
    tick(len);
    teclas = '0;
    tick(SETTLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NUM_TECLAS-1:0] key;
    int                    len;
    int                    dly;
    int                    exp_rises;
    int                    exp_multi;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int k, r0, m0, ones, len;
    logic [NUM_TECLAS-1:0] key;

    tbl[0] = '{10'b0000000100, 7,  0, 1, 0};
    tbl[1] = '{10'b1000000000, DC + 1, 0, 1, 0};
    tbl[2] = '{10'b0000000001, DC, 0, 0, 0};
    tbl[3] = '{10'b0000100001, 10, 0, 0, 1};
    tbl[4] = '{10'b1111111111, 8,  0, 0, 1};
    tbl[5] = '{10'b0000000010, 6,  5, 1, 0};
    tbl[6] = '{10'b0001000000, 1,  0, 0, 0};
    tbl[7] = '{10'b0000000000, 10, 0, 0, 0};
    tbl[8] = '{10'b0100000000, 7,  3, 1, 0};
    tbl[9] = '{10'b0000011000, 2,  0, 0, 1};

    // Reset state
    tick(2);
    check("reset_D", {22'd0, bus.D}, 32'd0);
    check("reset_valid", {31'd0, bus.valid}, 32'd0);
    check("reset_multi_err", {31'd0, bus.multi_err}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    #2 rst_n = 1'b1;
    tick(3);

    // Table-driven single sessions
    for (int i = 0; i < 10; i++) begin
      r0 = n_rise;
      m0 = n_multi;
      ack_dly = tbl[i].dly;
      if (tbl[i].exp_rises != 0) exp_q.push_back(tbl[i].key);
      session(tbl[i].key, tbl[i].len);
      check($sformatf("tbl%0d_rises", i), n_rise - r0, tbl[i].exp_rises);
      check($sformatf("tbl%0d_multi", i), n_multi - m0, tbl[i].exp_multi);
    end
    ack_dly = 0;

    // Press held, immediate ack: latency, one-clock valid, no second event while held
    r0 = n_rise;
    exp_q.push_back(10'b0000000100);
    teclas = 10'b0000000100;
    wait_valid(k);
    check("t1_latency", k, LAT);
    @(negedge clk);
    check("t1_valid_one_clk", {31'd0, bus.valid}, 32'd0);
`ifndef AUTOREPEAT_EN
    tick(20 - LAT - 1);
`endif
    teclas = '0;
    tick(SETTLE);
    check("t1_single_event", n_rise - r0, 1);

    // Bouncing input, then steady
    r0 = n_rise;
    for (int i = 0; i < 6; i++) begin
      teclas = (i % 2 == 0) ? 10'b0000001000 : 10'b0000000000;
      tick(2);
    end
    check("t2_no_valid_while_bouncing", n_rise - r0, 0);
    exp_q.push_back(10'b0000001000);
    teclas = 10'b0000001000;
    wait_valid(k);
    check("t2_latency_after_settle", k, LAT);
    teclas = '0;
    tick(SETTLE);

    // Chord, release, minimum idle gap, then a new key
    m0 = n_multi;
    r0 = n_rise;
    teclas = 10'b0000100001;
    tick(6);
    teclas = '0;
    tick(DC);
    check("t3_multi_pulses", n_multi - m0, 1);
    check("t3_no_valid", n_rise - r0, 0);
    exp_q.push_back(10'b1000000000);
    teclas = 10'b1000000000;
    wait_valid(k);
    check("t3_latency_after_gap", k, LAT);
    teclas = '0;
    tick(SETTLE);

    // Late ack: valid and D held 30 clocks after release
    auto_ack = 1'b0;
    exp_q.push_back(10'b0000000010);
    teclas = 10'b0000000010;
    wait_valid(k);
    check("t4_latency", k, LAT);
    teclas = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("t4_valid_held", {31'd0, bus.valid}, 32'd1);
      check("t4_D_stable", {22'd0, bus.D}, {22'd0, 10'b0000000010});
    end
    man_ack = 1'b1;
    @(negedge clk);
    check("t4_valid_after_ack", {31'd0, bus.valid}, 32'd0);
    check("t4_D_after_ack", {22'd0, bus.D}, 32'd0);
    man_ack = 1'b0;
    tick(SETTLE);

    // Reset while valid is high, key still held
    exp_q.push_back(10'b0010000000);
    teclas = 10'b0010000000;
    wait_valid(k);
    check("t5_latency", k, LAT);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", {31'd0, bus.valid}, 32'd0);
    check("t5_async_D", {22'd0, bus.D}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    auto_ack = 1'b1;
    exp_q.push_back(10'b0010000000);
    wait_valid(k);
    check("t5_reaccept_latency", k, LAT);
    teclas = '0;
    tick(SETTLE);

`ifdef AUTOREPEAT_EN
    // Held key with immediate acks repeats every RC+1 clocks
    r0 = n_rise;
    rise_cyc_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(10'b0100000000);
    teclas = 10'b0100000000;
    k = 0;
    while (k < 200 && n_rise < r0 + 5) begin
      @(negedge clk);
      k++;
    end
    teclas = '0;
    check("t6_repeat_count", n_rise - r0, 5);
    for (int i = 1; i < 5 && i < rise_cyc_q.size(); i++)
      check($sformatf("t6_repeat_period%0d", i), rise_cyc_q[i] - rise_cyc_q[i-1], RC + 1);
    tick(SETTLE);
    check("t6_no_repeat_after_release", n_rise - r0, 5);
`endif

    // Randomized sessions against a press-level model: a lone key is accepted once if it stays
    // put for DC+1 synchronised samples; any chord gives one error pulse and no digit.
    for (int s = 0; s < 60; s++) begin
      key = '0;
      if ($urandom_range(0, 9) < 7) begin
        key[$urandom_range(0, NUM_TECLAS - 1)] = 1'b1;
      end else begin
        k = $urandom_range(0, NUM_TECLAS - 1);
        key[k] = 1'b1;
        key[(k + $urandom_range(1, NUM_TECLAS - 1)) % NUM_TECLAS] = 1'b1;
        key = key | NUM_TECLAS'($urandom_range(0, 1023) & $urandom_range(0, 1023));
      end
      ones = $countones(key);
      len = $urandom_range(1, LMAX);
      ack_dly = $urandom_range(0, 8);
      r0 = n_rise;
      m0 = n_multi;
      if (ones == 1 && len >= DC + 1) exp_q.push_back(key);
      session(key, len);
      check("rnd_rises", n_rise - r0, (ones == 1 && len >= DC + 1) ? 1 : 0);
      check("rnd_multi", n_multi - m0, (ones > 1) ? 1 : 0);
    end

    check("leftover_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (state=%0d)", dbg_state);
    $fatal(1, "watchdog");
  end
endmodule
